mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter FIXED_PRIO, default 0; 0 = round-robin between ports, 1 = port 0 always wins.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 M0Req / M1Req  input  1  port request (M0 = CPU load/store, M1 = debug/boot loader).
REQ-005 M0We / M1We  input  1  1 = store, 0 = load.
REQ-006 M0Funct3 / M1Funct3  input  3  access size/sign (byte, half, word, byte-unsigned, half-unsigned), riscv_pkg F3 encoding.
REQ-007 M0Addr / M1Addr  input  32  byte address.
REQ-008 M0WData / M1WData  input  32  store data.
REQ-009 M0Ready / M1Ready  output  1  one-cycle accept pulse.
REQ-010 M0RValid / M1RValid  output  1  one-cycle completion pulse.
REQ-011 M0RData / M1RData  output  32  load data, valid with RValid.
REQ-012 M0Err / M1Err  output  1  misaligned-access flag, valid with RValid.
REQ-013 MemWrite  output  1  data-memory write strobe.
REQ-014 MemFunct3  output  3  data-memory access size.
REQ-015 MemAddress  output  32  data-memory address.
REQ-016 MemWriteData  output  32  data-memory store data.
REQ-017 MemReadData  input  32  data-memory combinational read data.

Function
REQ-018 Handshake: requester holds Req and all fields stable until Ready; transfer occurs in the cycle Ready=1; Req may drop the cycle after.
REQ-019 FSM states IDLE, BUSY, RESP; IDLE->BUSY on any Req, BUSY->RESP always, RESP->IDLE always.
REQ-020 In IDLE with a Req, the winner gets Ready=1 that cycle and its request is latched; loser sees Ready=0 and keeps waiting.
REQ-021 Round-robin: on simultaneous requests the port not granted last wins; after reset port 0 has priority; single requester always wins.
REQ-022 In BUSY, Mem* outputs are driven from latched registers; MemWrite=1 only for an aligned store.
REQ-023 MemReadData is captured at the end of BUSY into the owner's RData register.
REQ-024 In RESP, owner's RValid=1 for exactly one cycle for loads and stores; RData = captured data for loads, 0 for stores.
REQ-025 Latency: Ready at cycle N, memory access at N+1, RValid at N+2; next Ready no earlier than N+3.
REQ-026 Misaligned (half with Addr[0]=1, word with Addr[1:0]!=0): MemWrite stays 0, RESP gives RData=0, Err=1.
REQ-027 Outside BUSY: MemWrite=0; MemAddress, MemWriteData, MemFunct3 hold last value (not required to zero).
REQ-028 Non-owner port never sees RValid/Err; RData of non-owner holds previous value.
REQ-029 Req arriving during BUSY/RESP is not accepted until the next IDLE; no request is lost or duplicated.
REQ-030 FIXED_PRIO=1: port 0 wins every tie; port 1 can starve (documented, intended).

Reset
REQ-031 rst_n low: state=IDLE, all Ready/RValid/Err=0, MemWrite=0, Mem* data/address=0, RData=0, round-robin pointer favours port 0.
REQ-032 Reset mid-transaction aborts it: no RValid issued, no memory write after rst_n asserts.

Structure
REQ-033 riscv_pkg gains arb_state_t (IDLE/BUSY/RESP) and the port-index type; F3 constants reused from riscv_pkg.
REQ-034 Grant logic is one sub-module, rr_arbiter2 (two requests, last-grant pointer, FIXED_PRIO pass-through).

Verification
REQ-035 Single M0 store word 0x100 data 0xDEADBEEF -> Ready cycle N, MemWrite=1 at N+1 with MemAddress=0x100, M0RValid N+2, Err=0.
REQ-036 M1 load word 0x100 after REQ-035, MemReadData=0xDEADBEEF -> M1RValid at N+2, M1RData=0xDEADBEEF, no M0 activity.
REQ-037 Both Req held continuously for 6 grants -> grants alternate M0,M1,M0,M1,M0,M1; with FIXED_PRIO=1 all six to M0.
REQ-038 M0 half store at 0x101 -> MemWrite never 1, M0RValid with M0Err=1, M0RData=0.
REQ-039 rst_n pulsed low during BUSY of an M1 store -> MemWrite=0 immediately, no M1RValid, next simultaneous request granted to M0.
REQ-040 M1 asserts Req during M0 RESP -> M1 Ready in the following IDLE cycle, exactly one M1 transaction.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: load/store funct3 encodings plus arbiter state and port-index types.
package riscv_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} arb_state_t;
  typedef logic port_idx_t;
  // Halves need bit 0 clear, words need bits 1:0 clear; the sign bit of funct3 is irrelevant.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    return (f3[1:0] == F3_H[1:0] && a[0]) || (f3[1:0] == F3_W[1:0] && a != 2'b00);
  endfunction
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way grant with last-grant pointer, or fixed port-0 priority.
module rr_arbiter2
  import riscv_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic [1:0] req,
  input  logic      take,
  output logic [1:0] gnt,
  output port_idx_t idx
);
  port_idx_t last_q;
  always_comb begin
    idx = (req == 2'b10) ? 1'b1 : (req == 2'b11 && !FIXED_PRIO && last_q == 1'b0) ? 1'b1 : 1'b0;
    gnt = (|req) ? (2'b01 << idx) : 2'b00;
  end
  // Reset value points at port 1 so port 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last_q <= 1'b1;
    else if (take && |req) last_q <= idx;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one data-memory port between a CPU port (M0) and a debug/boot port (M1).
module mem_arbiter
  import riscv_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        M0Req,
  input  logic        M0We,
  input  logic [2:0]  M0Funct3,
  input  logic [31:0] M0Addr,
  input  logic [31:0] M0WData,
  output logic        M0Ready,
  output logic        M0RValid,
  output logic [31:0] M0RData,
  output logic        M0Err,
  input  logic        M1Req,
  input  logic        M1We,
  input  logic [2:0]  M1Funct3,
  input  logic [31:0] M1Addr,
  input  logic [31:0] M1WData,
  output logic        M1Ready,
  output logic        M1RValid,
  output logic [31:0] M1RData,
  output logic        M1Err,
  output logic        MemWrite,
  output logic [2:0]  MemFunct3,
  output logic [31:0] MemAddress,
  output logic [31:0] MemWriteData,
  input  logic [31:0] MemReadData
);
  arb_state_t state_q, state_d;
  port_idx_t owner_q, win;
  logic [1:0] gnt;
  logic idle, we_q, mis_q;
  logic [2:0] f3_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] rdata_q [2];
  assign idle = state_q == IDLE;
  rr_arbiter2 #(.FIXED_PRIO(FIXED_PRIO)) u_rr (
    .clk  (clk),
    .rst_n(rst_n),
    .req  ({M1Req, M0Req}),
    .take (idle),
    .gnt  (gnt),
    .idx  (win)
  );
  always_comb begin
    state_d = idle ? ((M0Req || M1Req) ? BUSY : IDLE) : (state_q == BUSY) ? RESP : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      mis_q      <= 1'b0;
      f3_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q[0] <= '0;
      rdata_q[1] <= '0;
    end else begin
      state_q <= state_d;
      if (idle && |gnt) begin
        owner_q <= win;
        we_q    <= win ? M1We : M0We;
        f3_q    <= win ? M1Funct3 : M0Funct3;
        addr_q  <= win ? M1Addr : M0Addr;
        wdata_q <= win ? M1WData : M0WData;
        mis_q   <= misaligned(win ? M1Funct3 : M0Funct3, win ? M1Addr[1:0] : M0Addr[1:0]);
      end
      // Stores and faulted accesses return zero data.
      if (state_q == BUSY) rdata_q[owner_q] <= (we_q || mis_q) ? '0 : MemReadData;
    end
  assign M0Ready      = idle && gnt[0];
  assign M1Ready      = idle && gnt[1];
  assign M0RValid     = state_q == RESP && owner_q == 1'b0;
  assign M1RValid     = state_q == RESP && owner_q == 1'b1;
  assign M0Err        = M0RValid && mis_q;
  assign M1Err        = M1RValid && mis_q;
  assign M0RData      = rdata_q[0];
  assign M1RData      = rdata_q[1];
  assign MemWrite     = state_q == BUSY && we_q && !mis_q;
  assign MemFunct3    = f3_q;
  assign MemAddress   = addr_q;
  assign MemWriteData = wdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus against a cycle-count transaction model of the arbiter.
module tb_mem_arbiter;
  import riscv_pkg::*;
  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] req, we;
  logic [2:0] f3 [2];
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic M0Ready, M0RValid, M0Err, M1Ready, M1RValid, M1Err, MemWrite;
  logic [31:0] M0RData, M1RData, MemAddress, MemWriteData, MemReadData;
  logic [2:0] MemFunct3;
  logic [1:0] rdy, rv, er;
  logic [31:0] physmem [256];
  logic [31:0] shadow [256];
  int vec = 0, err = 0, cyc = 0;

  always #5 clk = ~clk;
  assign rdy = {M1Ready, M0Ready};
  assign rv  = {M1RValid, M0RValid};
  assign er  = {M1Err, M0Err};
  assign MemReadData = physmem[MemAddress[9:2]];

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .M0Req(req[0]), .M0We(we[0]), .M0Funct3(f3[0]), .M0Addr(addr[0]), .M0WData(wdata[0]),
    .M0Ready(M0Ready), .M0RValid(M0RValid), .M0RData(M0RData), .M0Err(M0Err),
    .M1Req(req[1]), .M1We(we[1]), .M1Funct3(f3[1]), .M1Addr(addr[1]), .M1WData(wdata[1]),
    .M1Ready(M1Ready), .M1RValid(M1RValid), .M1RData(M1RData), .M1Err(M1Err),
    .MemWrite(MemWrite), .MemFunct3(MemFunct3), .MemAddress(MemAddress),
    .MemWriteData(MemWriteData), .MemReadData(MemReadData)
  );

  logic [1:0] fp_req;
  logic fp_on;
  logic fp_r0, fp_r1, fp_v0, fp_v1, fp_e0, fp_e1, fp_mw;
  logic [31:0] fp_d0, fp_d1, fp_ma, fp_mwd;
  logic [2:0] fp_mf3;
  int fp_n0 = 0, fp_n1 = 0;
  mem_arbiter #(.FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .M0Req(fp_req[0]), .M0We(1'b0), .M0Funct3(F3_W), .M0Addr(32'h0), .M0WData(32'h0),
    .M0Ready(fp_r0), .M0RValid(fp_v0), .M0RData(fp_d0), .M0Err(fp_e0),
    .M1Req(fp_req[1]), .M1We(1'b0), .M1Funct3(F3_W), .M1Addr(32'h4), .M1WData(32'h0),
    .M1Ready(fp_r1), .M1RValid(fp_v1), .M1RData(fp_d1), .M1Err(fp_e1),
    .MemWrite(fp_mw), .MemFunct3(fp_mf3), .MemAddress(fp_ma),
    .MemWriteData(fp_mwd), .MemReadData(32'h0)
  );
  always @(negedge clk)
    if (fp_on) begin
      fp_n0 += int'(fp_r0);
      fp_n1 += int'(fp_r1);
    end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model state: one outstanding transaction identified by its grant cycle.
  int next_ok = 0, last = 1, t_g = 0, t_o = 0, w = 0;
  bit have = 0, t_we = 0, t_mis = 0, e_mw = 0;
  logic [2:0] t_f3;
  logic [31:0] t_a, t_wd, t_rd;
  logic [31:0] exp_rd [2];
  logic [1:0] e_rdy, e_rv, e_err;
  int g_port[$], g_cyc[$];
  int mw_cnt = 0, mw_cyc = -1, rv0_cyc = -1, rv1_cyc = -1, rv_cnt0 = 0, rv_cnt1 = 0, err0_cnt = 0;
  logic [31:0] mw_addr = 0;

  always @(negedge clk) begin
    if (cyc == 0)
      for (int i = 0; i < 256; i++) begin
        physmem[i] = 32'hA500_0000 | 32'(i);
        shadow[i]  = 32'hA500_0000 | 32'(i);
      end
    if (!rst_n) begin
      chk("rst_ready", 32'(rdy), 0);
      chk("rst_rvalid", 32'(rv), 0);
      chk("rst_err", 32'(er), 0);
      chk("rst_memwrite", 32'(MemWrite), 0);
      chk("rst_memaddr", MemAddress, 0);
      chk("rst_memwdata", MemWriteData, 0);
      chk("rst_memf3", 32'(MemFunct3), 0);
      chk("rst_rdata0", M0RData, 0);
      chk("rst_rdata1", M1RData, 0);
      have = 0; last = 1; exp_rd[0] = 0; exp_rd[1] = 0; next_ok = cyc + 1;
    end else begin
      e_rdy = 0; e_rv = 0; e_err = 0; e_mw = 0;
      if (have && cyc == t_g + 1) begin
        e_mw = t_we && !t_mis;
        chk("busy_addr", MemAddress, t_a);
        chk("busy_f3", 32'(MemFunct3), 32'(t_f3));
        chk("busy_wdata", MemWriteData, t_wd);
        t_rd = (t_we || t_mis) ? 32'h0 : shadow[t_a[9:2]];
        if (e_mw) shadow[t_a[9:2]] = t_wd;
      end
      if (have && cyc == t_g + 2) begin
        e_rv[t_o] = 1'b1;
        e_err[t_o] = t_mis;
        exp_rd[t_o] = t_rd;
        have = 0;
      end
      if (cyc >= next_ok && |req) begin
        w = (req == 2'b11) ? (last == 1 ? 0 : 1) : (req[1] ? 1 : 0);
        e_rdy[w] = 1'b1;
        have = 1; t_g = cyc; t_o = w; last = w; next_ok = cyc + 3;
        t_we = we[w]; t_f3 = f3[w]; t_a = addr[w]; t_wd = wdata[w];
        t_mis = (f3[w][1:0] == 2'b01 && addr[w][0]) || (f3[w][1:0] == 2'b10 && addr[w][1:0] != 2'b00);
      end
      chk("ready", 32'(rdy), 32'(e_rdy));
      chk("rvalid", 32'(rv), 32'(e_rv));
      chk("err", 32'(er), 32'(e_err));
      chk("memwrite", 32'(MemWrite), 32'(e_mw));
      chk("rdata0", M0RData, exp_rd[0]);
      chk("rdata1", M1RData, exp_rd[1]);
    end
    if (M0Ready) begin g_port.push_back(0); g_cyc.push_back(cyc); end
    if (M1Ready) begin g_port.push_back(1); g_cyc.push_back(cyc); end
    if (MemWrite) begin
      mw_cnt++; mw_cyc = cyc; mw_addr = MemAddress;
      physmem[MemAddress[9:2]] = MemWriteData;
    end
    if (M0RValid) begin rv_cnt0++; rv0_cyc = cyc; end
    if (M1RValid) begin rv_cnt1++; rv1_cyc = cyc; end
    if (M0Err) err0_cnt++;
    cyc++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_req(input int p, input logic w_, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    we[p] = w_; f3[p] = f; addr[p] = a; wdata[p] = d; req[p] = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!rdy[p] && n < 20);
    chk("handshake_ready", 32'(rdy[p]), 1);
    @(posedge clk);
    #1;
    req[p] = 1'b0;
  endtask

  int k, v, m, e, n;
  initial begin
    rst_n = 1'b0; req = 0; we = 0; fp_req = 0; fp_on = 0;
    f3[0] = 0; f3[1] = 0; addr[0] = 0; addr[1] = 0; wdata[0] = 0; wdata[1] = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    step(1);
    k = g_port.size();
    do_req(0, 1'b1, F3_W, 32'h100, 32'hDEADBEEF);
    step(3);
    chk("t035_port", g_port[k], 0);
    chk("t035_mw_cycle", mw_cyc, g_cyc[k] + 1);
    chk("t035_mw_addr", mw_addr, 32'h100);
    chk("t035_rv_cycle", rv0_cyc, g_cyc[k] + 2);
    chk("t035_mem", physmem[8'h40], 32'hDEADBEEF);
    k = g_port.size(); v = rv_cnt0;
    do_req(1, 1'b0, F3_W, 32'h100, 32'h0);
    step(3);
    chk("t036_port", g_port[k], 1);
    chk("t036_rv_cycle", rv1_cyc, g_cyc[k] + 2);
    chk("t036_rdata", M1RData, 32'hDEADBEEF);
    chk("t036_no_m0", rv_cnt0, v);
    m = mw_cnt; e = err0_cnt;
    do_req(0, 1'b1, F3_H, 32'h101, 32'hCAFE);
    step(3);
    chk("t038_no_write", mw_cnt, m);
    chk("t038_err", err0_cnt, e + 1);
    chk("t038_rdata", M0RData, 0);
    do_req(1, 1'b0, F3_W, 32'h104, 32'h0);
    step(3);
    chk("pre037_rdata", M1RData, 32'hA500_0041);
    k = g_port.size();
    fork
      begin for (int i = 0; i < 3; i++) do_req(0, 1'b0, F3_W, 32'h10 + 32'(4 * i), 32'h0); end
      begin for (int i = 0; i < 3; i++) do_req(1, 1'b0, F3_W, 32'h20 + 32'(4 * i), 32'h0); end
    join
    step(3);
    for (int i = 0; i < 6; i++) chk("t037_rr_order", g_port[k + i], i % 2);
    fp_req = 2'b11; fp_on = 1'b1; n = 0;
    while (fp_n0 + fp_n1 < 6 && n < 40) begin step(1); n++; end
    fp_req = 2'b00; fp_on = 1'b0;
    chk("t037_fixed_m0", fp_n0, 6);
    chk("t037_fixed_m1", fp_n1, 0);
    v = rv_cnt1;
    do_req(1, 1'b1, F3_W, 32'h200, 32'h12345678);
    rst_n = 1'b0;
    #1 chk("t039_mw_rst", 32'(MemWrite), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(4);
    chk("t039_no_rvalid", rv_cnt1, v);
    chk("t039_mem", physmem[8'h80], 32'hA500_0080);
    k = g_port.size();
    fork
      do_req(0, 1'b0, F3_W, 32'h30, 32'h0);
      do_req(1, 1'b0, F3_W, 32'h34, 32'h0);
    join
    step(3);
    chk("t039_first", g_port[k], 0);
    chk("t039_second", g_port[k + 1], 1);
    k = g_port.size(); v = rv_cnt1;
    do_req(0, 1'b0, F3_W, 32'h38, 32'h0);
    step(1);
    do_req(1, 1'b0, F3_W, 32'h3C, 32'h0);
    step(4);
    chk("t040_m0", g_port[k], 0);
    chk("t040_m1", g_port[k + 1], 1);
    chk("t040_gap", g_cyc[k + 1] - g_cyc[k], 3);
    chk("t040_once", rv_cnt1, v + 1);
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
